// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: funct3 size codes, the captured
// request record and the responder FSM states.
package mem_io;

  localparam int MAX_XLEN = 64;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // Address and data are held at the widest supported XLEN; narrower
  // instances only use the low XLEN bits.
  typedef struct packed {
    logic                we;
    logic [2:0]          funct3;
    logic [MAX_XLEN-1:0] addr;
    logic [MAX_XLEN-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: byte enables and merged store word, lane
// extraction with sign/zero extension for loads, and illegal/misaligned detection.
module dmem_lane_align
  import mem_io::*;
#(
  parameter  int XLEN = 64,
  localparam int NB   = XLEN / 8,
  localparam int OFF  = $clog2(NB)
) (
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [OFF-1:0]  offset,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wword,
  output logic [XLEN-1:0] rdata,
  output logic            err
);

  logic            illegal;
  logic            misaligned;
  logic            sign;
  logic [3:0]      nbytes;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wshift;
  int              lo;
  int              nbits;

  // Stores only use the signed size codes; D and WU need a 64-bit datapath.
  always_comb begin
    nbytes     = size_bytes(funct3);
    illegal    = (funct3 == F3_BAD) || (we && funct3[2]) ||
                 ((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));
    misaligned = (({{(4-OFF){1'b0}}, offset} & (nbytes - 4'd1)) != 4'd0);
    err        = illegal || misaligned;
  end

  always_comb begin
    lo      = int'(offset);
    nbits   = int'(nbytes) * 8;
    shifted = word >> {offset, 3'b000};
    wshift  = wdata << {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   sign = shifted[7];
      2'b01:   sign = shifted[15];
      2'b10:   sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    sign  = sign & ~funct3[2];
    rdata = '0;
    be    = '0;
    wword = word;
    for (int i = 0; i < XLEN; i++) begin
      if (!err) begin
        rdata[i] = (i < nbits) ? shifted[i] : sign;
      end
    end
    for (int b = 0; b < NB; b++) begin
      be[b]          = !err && (b >= lo) && (b < lo + int'(nbytes));
      wword[8*b +: 8] = be[b] ? wshift[8*b +: 8] : word[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store, waits LATENCY
// cycles, then presents a registered response until the requester takes it.
module dmem_responder
  import mem_io::*;
#(
  parameter  int XLEN       = 64,
  parameter  int ADDR_WIDTH = 8,
  parameter  int LATENCY    = 2,
  localparam int NB         = XLEN / 8,
  localparam int OFF        = $clog2(NB),
  localparam int DEPTH      = 2 ** ADDR_WIDTH,
  localparam int CW         = (LATENCY < 2) ? 1 : $clog2(LATENCY)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);

  dmem_state_t           state_q;
  dmem_state_t           state_d;
  mem_req_t              req_in;
  mem_req_t              req_q;
  mem_req_t              cur;
  logic [CW-1:0]         count_q;
  logic [XLEN-1:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [OFF-1:0]        offset;
  logic                  accept;
  logic                  enter_resp;
  logic [NB-1:0]         be;
  logic [XLEN-1:0]       wword;
  logic [XLEN-1:0]       ld_data;
  logic                  err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (count_q == CW'(1)) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With LATENCY=1 the array is accessed on the accept edge itself, so the
  // live request is used while IDLE and the captured one afterwards.
  always_comb begin
    req_in                  = '0;
    req_in.we               = req_we;
    req_in.funct3           = req_funct3;
    req_in.addr[XLEN-1:0]   = req_addr;
    req_in.wdata[XLEN-1:0]  = req_wdata;
    cur    = (state_q == IDLE) ? req_in : req_q;
    idx    = cur.addr[ADDR_WIDTH+OFF-1:OFF];
    offset = cur.addr[OFF-1:0];
  end

  dmem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .we    (cur.we),
    .funct3(cur.funct3),
    .offset(offset),
    .word  (mem[idx]),
    .wdata (cur.wdata[XLEN-1:0]),
    .be    (be),
    .wword (wword),
    .rdata (ld_data),
    .err   (err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      count_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        req_q   <= req_in;
        count_q <= CW'(LATENCY - 1);
      end else if (state_q == WAIT) begin
        count_q <= count_q - CW'(1);
      end
      if (enter_resp) begin
        rsp_rdata <= cur.we ? '0 : ld_data;
        rsp_err   <= err;
      end else if (rsp_valid && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Storage is never reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur.we && !err && (be != '0)) begin
      mem[idx] <= wword;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads/stores of every size, misalignment,
// illegal codes, response back-pressure, mid-request reset and address wrap.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  logic [63:0] rd;
  logic        er;
  logic [63:0] held;

  dmem_responder #(
    .XLEN(64),
    .ADDR_WIDTH(8),
    .LATENCY(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, actual, expected);
    end
  endtask

  // Issue one request, check its latency, take the response and check handoff.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
    int cycles;
    @(negedge clk);
    checkOutput("ready_before_req", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cycles = 1;
    while (!rsp_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("latency", 64'(cycles), 64'd2);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("handoff_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rdata", rsp_rdata, 64'd0);
    checkOutput("rst_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd, er);
    checkOutput("sd_rdata", rd, 64'd0);
    checkOutput("sd_err", 64'(er), 64'd0);
    applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
    checkOutput("ld_rdata", rd, 64'h1122334455667788);
    checkOutput("ld_err", 64'(er), 64'd0);

    applyStimulus(1'b1, 3'b000, 64'h13, 64'h80, rd, er);
    checkOutput("sb_err", 64'(er), 64'd0);
    applyStimulus(1'b0, 3'b000, 64'h13, 64'd0, rd, er);
    checkOutput("lb_rdata", rd, 64'hFFFFFFFFFFFFFF80);
    applyStimulus(1'b0, 3'b100, 64'h13, 64'd0, rd, er);
    checkOutput("lbu_rdata", rd, 64'h80);
    applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
    checkOutput("ld_after_sb", rd, 64'h1122334480667788);
    applyStimulus(1'b0, 3'b001, 64'h12, 64'd0, rd, er);
    checkOutput("lh_rdata", rd, 64'hFFFFFFFFFFFF8066);
    applyStimulus(1'b0, 3'b010, 64'h10, 64'd0, rd, er);
    checkOutput("lw_rdata", rd, 64'hFFFFFFFF80667788);
    applyStimulus(1'b0, 3'b110, 64'h14, 64'd0, rd, er);
    checkOutput("lwu_rdata", rd, 64'h11223344);

    applyStimulus(1'b0, 3'b010, 64'h12, 64'd0, rd, er);
    checkOutput("lw_mis_err", 64'(er), 64'd1);
    checkOutput("lw_mis_rdata", rd, 64'd0);
    applyStimulus(1'b1, 3'b001, 64'h11, 64'hBEEF, rd, er);
    checkOutput("sh_mis_err", 64'(er), 64'd1);
    applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
    checkOutput("ld_after_sh_mis", rd, 64'h1122334480667788);

    // Back-pressure: response must hold while rsp_ready stays low.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = 64'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hold_first_valid", 64'(rsp_valid), 64'd1);
    held = rsp_rdata;
    checkOutput("hold_first_rdata", held, 64'h1122334480667788);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 64'(rsp_valid), 64'd1);
      checkOutput("hold_rdata", rsp_rdata, 64'h1122334480667788);
      checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
      checkOutput("hold_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("release_valid", 64'(rsp_valid), 64'd0);
    checkOutput("release_ready", 64'(req_ready), 64'd1);
    checkOutput("release_busy", 64'(busy), 64'd0);

    // Reset one cycle after a store is accepted: the store must be dropped.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b011;
    req_addr   = 64'h10;
    req_wdata  = 64'hDEADBEEFCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
    checkOutput("ld_after_midrst", rd, 64'h1122334480667788);

    // Upper address bits wrap onto the same word.
    applyStimulus(1'b1, 3'b011, 64'h10 + 64'd2048, 64'hA5A5A5A55A5A5A5A, rd, er);
    checkOutput("sd_wrap_err", 64'(er), 64'd0);
    applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
    checkOutput("ld_wrap_rdata", rd, 64'hA5A5A5A55A5A5A5A);
    applyStimulus(1'b0, 3'b111, 64'h10, 64'd0, rd, er);
    checkOutput("f3_111_err", 64'(er), 64'd1);
    checkOutput("f3_111_rdata", rd, 64'd0);
    applyStimulus(1'b1, 3'b100, 64'h10, 64'h12, rd, er);
    checkOutput("st_unsigned_err", 64'(er), 64'd1);
    applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
    checkOutput("ld_after_illegal_st", rd, 64'hA5A5A5A55A5A5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
